imem_stream_loader: RTL and testbench

Hardware program loader that sits directly upstream of the pipeline's byte-addressed instruction/data memory (MEM1). It accepts 32-bit program words over a valid/ready stream and writes each word into memory as four bytes, least-significant byte at the lowest address. Optionally it zero-fills the rest of the memory. It holds the CPU in stall until the image is complete, so the pipeline boots without a testbench backdoor.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/imem_byte_serializer.sv | 61 ++++++
 rtl/imem_stream_loader.sv | 158 +++++++++++++++
 tb/tb_imem_stream_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared state encoding and constants for the instruction-memory stream loader.
package pipeline_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_FILL,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits a 32-bit word into four byte beats, least-significant byte first,
// starting the cycle after the load pulse.
module imem_byte_serializer
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  byte_data,
    output logic        byte_strobe,
    output logic        last_byte
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [7:0] lane     [BYTES_PER_WORD];
    logic [7:0] lane_reg [BYTES_PER_WORD];
    logic [7:0] byte_reg;
    logic [1:0] idx_reg;
    logic [1:0] idx_next;
    logic       strobe_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign idx_next = idx_reg + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_reg   <= '{default: 8'h00};
            byte_reg   <= 8'h00;
            idx_reg    <= 2'd0;
            strobe_reg <= 1'b0;
        end else if (load) begin
            lane_reg   <= lane;
            byte_reg   <= lane[0];
            idx_reg    <= 2'd0;
            strobe_reg <= 1'b1;
        end else if (strobe_reg) begin
            if (idx_reg == LAST_IDX) begin
                // Park the data bus at zero so fill cycles drive 0x00.
                strobe_reg <= 1'b0;
                byte_reg   <= 8'h00;
                idx_reg    <= 2'd0;
            end else begin
                byte_reg <= lane_reg[idx_next];
                idx_reg  <= idx_next;
            end
        end
    end

    assign byte_data   = byte_reg;
    assign byte_strobe = strobe_reg;
    assign last_byte   = strobe_reg && (idx_reg == LAST_IDX);

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a word stream into byte-addressed memory (LSB at lowest address),
// optionally zero-fills the remainder, and holds the CPU until the image is in.
module imem_stream_loader
    import pipeline_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ZERO_FILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    loader_state_t    state_reg;
    logic [ADDR_W:0]  ptr_reg;
    logic [ADDR_W:0]  count_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic             mem_we_reg;
    logic             last_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             ovf_reg;
    logic             hold_reg;

    logic             ser_load;
    logic [7:0]       ser_byte;
    logic             ser_strobe;
    logic             ser_last;
    logic             room;
    logic             byte_due;

    // ready_reg is high exactly while in LOAD, so the state test is the handshake.
    assign ser_load = (state_reg == ST_LOAD) && in_valid;
    assign room     = ptr_reg < DEPTH_P;
    assign byte_due = ser_load ||
                      ((state_reg == ST_WRITE) && ser_strobe && !ser_last);

    imem_byte_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ser_load),
        .word        (in_data),
        .byte_data   (ser_byte),
        .byte_strobe (ser_strobe),
        .last_byte   (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            count_reg    <= '0;
            mem_addr_reg <= '0;
            mem_we_reg   <= 1'b0;
            last_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            hold_reg     <= 1'b1;
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_LOAD;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        hold_reg  <= 1'b1;
                        ptr_reg   <= '0;
                        count_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        last_reg  <= in_last;
                        ready_reg <= 1'b0;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ser_last) begin
                        if (!last_reg) begin
                            state_reg <= ST_LOAD;
                            ready_reg <= 1'b1;
                        end else if ((ZERO_FILL != 0) && room) begin
                            state_reg    <= ST_FILL;
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= ptr_reg[ADDR_W-1:0];
                            ptr_reg      <= ptr_reg + PTR_ONE;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            hold_reg  <= 1'b0;
                        end
                    end
                end
                ST_FILL: begin
                    // room drops once the DEPTH-1 write is on the bus.
                    if (room) begin
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= ptr_reg[ADDR_W-1:0];
                        ptr_reg      <= ptr_reg + PTR_ONE;
                    end else begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        hold_reg  <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Launch the next stream byte; past the end of memory it is dropped.
            if (byte_due) begin
                if (room) begin
                    mem_we_reg   <= 1'b1;
                    mem_addr_reg <= ptr_reg[ADDR_W-1:0];
                    ptr_reg      <= ptr_reg + PTR_ONE;
                    count_reg    <= count_reg + PTR_ONE;
                end else begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = ready_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = ser_byte;
    assign mem_we     = mem_we_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign overflow   = ovf_reg;
    assign cpu_hold   = hold_reg;
    assign byte_count = count_reg;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Drives three loader instances (large/no-fill, 16-byte/fill, 8-byte/fill) with
// the same word stream and checks each against an image-level memory model.
module tb_imem_stream_loader;

    localparam int NDUT = 3;
    localparam logic [7:0] SENT = 8'h5A;

    function automatic int dep_of(input int i);
        return (i == 0) ? 64 : ((i == 1) ? 16 : 8);
    endfunction

    function automatic int zf_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;

    logic [31:0] o_addr  [NDUT];
    logic [31:0] o_wdata [NDUT];
    logic [31:0] o_bc    [NDUT];
    logic        o_ready [NDUT];
    logic        o_we    [NDUT];
    logic        o_busy  [NDUT];
    logic        o_done  [NDUT];
    logic        o_ovf   [NDUT];
    logic        o_hold  [NDUT];

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int D  = dep_of(gi);
            localparam int AW = $clog2(D);
            logic [AW-1:0] addr;
            logic [AW:0]   bc;
            logic [7:0]    wd;
            logic          rdy, we, bsy, dn, ov, hd;

            imem_stream_loader #(
                .DEPTH     (D),
                .ADDR_W    (AW),
                .ZERO_FILL (zf_of(gi))
            ) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start),
                .in_data    (in_data),
                .in_valid   (in_valid),
                .in_last    (in_last),
                .in_ready   (rdy),
                .mem_addr   (addr),
                .mem_wdata  (wd),
                .mem_we     (we),
                .busy       (bsy),
                .done       (dn),
                .overflow   (ov),
                .cpu_hold   (hd),
                .byte_count (bc)
            );

            assign o_addr[gi]  = 32'(addr);
            assign o_wdata[gi] = 32'(wd);
            assign o_bc[gi]    = 32'(bc);
            assign o_ready[gi] = rdy;
            assign o_we[gi]    = we;
            assign o_busy[gi]  = bsy;
            assign o_done[gi]  = dn;
            assign o_ovf[gi]   = ov;
            assign o_hold[gi]  = hd;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed memory and stream activity per instance.
    logic [7:0]  mem      [NDUT][64];
    logic [31:0] acc_w    [NDUT][8];
    int          acc_n    [NDUT];
    int          last_acc [NDUT];
    int          nwr      [NDUT];
    int          done_cyc [NDUT];
    bit          done_seen[NDUT];

    logic [31:0] img [$];

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst_n && in_valid && o_ready[i]) begin
                check($sformatf("d%0d_accept_gap", i), 32'((cyc + 1 - last_acc[i]) >= 5), 32'd1);
                if (acc_n[i] < 8) acc_w[i][acc_n[i]] = in_data;
                acc_n[i]++;
                last_acc[i] = cyc + 1;
            end
            if (o_we[i]) begin
                mem[i][o_addr[i][5:0]] = o_wdata[i][7:0];
                nwr[i]++;
            end
            if (o_done[i] && !done_seen[i]) begin
                done_seen[i] = 1'b1;
                done_cyc[i]  = cyc;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NDUT; i++) begin
            for (int a = 0; a < 64; a++) mem[i][a] = SENT;
            acc_n[i]     = 0;
            last_acc[i]  = -100;
            nwr[i]       = 0;
            done_seen[i] = 1'b0;
            done_cyc[i]  = 0;
        end
    endtask

    task automatic check_reset(input string ctx);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_d%0d_flags", ctx, i),
                  {26'd0, o_ready[i], o_we[i], o_busy[i], o_done[i], o_ovf[i], o_hold[i]}, 32'h01);
            check($sformatf("%s_d%0d_addr", ctx, i), o_addr[i], 32'd0);
            check($sformatf("%s_d%0d_wdata", ctx, i), o_wdata[i], 32'd0);
            check($sformatf("%s_d%0d_count", ctx, i), o_bc[i], 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_image(input int id);
        int n, d, stream, wr, fill;
        logic [7:0] eb;
        n = img.size();
        for (int i = 0; i < NDUT; i++) begin
            d      = dep_of(i);
            stream = 4 * n;
            wr     = (stream < d) ? stream : d;
            fill   = (zf_of(i) != 0 && stream < d) ? d - stream : 0;
            check($sformatf("img%0d_d%0d_words", id, i), 32'(acc_n[i]), 32'(n));
            for (int k = 0; k < n && k < 8; k++)
                check($sformatf("img%0d_d%0d_word%0d", id, i, k), acc_w[i][k], img[k]);
            for (int a = 0; a < d; a++) begin
                if (a < wr) eb = 8'(img[a / 4] >> (8 * (a % 4)));
                else        eb = (zf_of(i) != 0) ? 8'h00 : SENT;
                check($sformatf("img%0d_d%0d_mem%0d", id, i, a), 32'(mem[i][a]), 32'(eb));
            end
            check($sformatf("img%0d_d%0d_writes", id, i), 32'(nwr[i]), 32'(wr + fill));
            check($sformatf("img%0d_d%0d_done_lat", id, i), 32'(done_cyc[i] - last_acc[i]), 32'(4 + fill));
            check($sformatf("img%0d_d%0d_status", id, i),
                  {26'd0, o_ready[i], o_we[i], o_busy[i], o_done[i], o_ovf[i], o_hold[i]},
                  {26'd0, 1'b0, 1'b0, 1'b0, 1'b1, (stream > d), 1'b0});
            check($sformatf("img%0d_d%0d_count", id, i), o_bc[i], 32'(wr));
        end
    endtask

    task automatic load_image(input int id, input bit rand_mode);
        int  tmo;
        bit  acc;
        bit  all_done;
        pulse_start();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("img%0d_d%0d_started", id, i),
                  {26'd0, o_ready[i], o_we[i], o_busy[i], o_done[i], o_ovf[i], o_hold[i]}, 32'h29);
            check($sformatf("img%0d_d%0d_count0", id, i), o_bc[i], 32'd0);
        end
        clear_model();
        for (int k = 0; k < img.size(); k++) begin
            in_data = img[k];
            in_last = (k == img.size() - 1);
            tmo = 0;
            acc = 1'b0;
            while (!acc && tmo < 100) begin
                in_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                start    = rand_mode && ($urandom_range(0, 7) == 0);
                acc      = in_valid && o_ready[0];
                @(posedge clk); #1;
                tmo++;
            end
            if (!acc) check($sformatf("img%0d_word%0d_accepted", id, k), 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        tmo = 0;
        all_done = 1'b0;
        while (!all_done && tmo < 300) begin
            all_done = o_done[0] && o_done[1] && o_done[2];
            if (!all_done) begin
                @(posedge clk); #1;
                tmo++;
            end
        end
        check($sformatf("img%0d_all_done", id), 32'(all_done), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_image(id);
        $display("image %0d: %0d words loaded (random valid=%0d)", id, img.size(), rand_mode);
    endtask

    initial begin
        int tmo;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_data  = 32'd0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        img = '{32'h11223344, 32'hAABBCCDD};
        load_image(0, 1'b0);

        img = '{32'hDEADBEEF};
        load_image(1, 1'b0);

        img = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        load_image(2, 1'b0);

        // Abort in the middle of writing the second word.
        pulse_start();
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = $urandom;
        @(posedge clk); #1;
        in_data = $urandom;
        tmo = 0;
        while (!o_ready[0] && tmo < 20) begin
            @(posedge clk); #1;
            tmo++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset("abort");
        $display("reset abort during second word write");

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 6);
            img.delete();
            for (int k = 0; k < n; k++) img.push_back($urandom);
            load_image(3 + t, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
